// File: rtl/decode_pipe.sv
`timescale 1ns/1ps
// decode_pipe: registered decode stage (ID/EX) with valid/ready on both sides, load-use bubbles and flush.
// Optional: define DECODE_MUL_INTERLOCK_EN to add the multi-cycle MUL issue interlock (mul_cnt).
module decode_pipe #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            F_valid,
  input  logic [XLEN-1:0] F_inst,
  output logic            F_ready,
  input  logic            flush,
  input  logic            E_ready,
  output logic            E_valid,
  output logic [5:0]      E_opc,
  output logic [4:0]      E_ra,
  output logic [4:0]      E_rb,
  output logic [4:0]      E_rd,
  output logic [XLEN-1:0] E_imm,
  output logic            E_we,
  output logic [3:0]      E_alu_op,
  output logic            E_ld,
  output logic            E_str,
  output logic            E_byt,
  output logic            E_brn,
  output logic            E_addi,
  output logic            E_mul,
  output logic            D_stall
);

  typedef struct packed {
    logic       we;
    logic [3:0] alu_op;
    logic       ld;
    logic       str;
    logic       byt;
    logic       brn;
    logic       addi;
    logic       mul;
  } ctl_t;

  function automatic ctl_t decode_ctl(input logic [5:0] opc, input logic [4:0] rd);
    ctl_t c;
    c = '0;
    case (opc)
      6'd0, 6'd1, 6'd2, 6'd3,
      6'd4, 6'd5, 6'd6, 6'd7: c.alu_op = opc[3:0];
      6'd8:  c.addi = 1'b1;
      6'd9:  c.alu_op = 4'd9;
      6'd10: c.alu_op = 4'd10;
      6'd13: begin
        c.brn = 1'b1;
        case (rd)
          5'd1:    c.alu_op = 4'd8;
          5'd2:    c.alu_op = 4'd9;
          5'd3:    c.alu_op = 4'd10;
          default: c.alu_op = 4'd0;
        endcase
      end
      6'd14: begin
        c.alu_op = 4'd11;
        c.mul    = 1'b1;
      end
      default: c.alu_op = 4'd0;
    endcase
    // Memory and width flags come from the low/high opcode bits, independent of the table above.
    c.ld  = (opc[4:0] == 5'b01011);
    c.str = (opc[4:0] == 5'b01100);
    c.byt = opc[5];
    c.we  = (opc <= 6'd10) | c.ld | c.mul;
    return c;
  endfunction

  function automatic logic signed [XLEN-1:0] sext_imm(input logic [10:0] raw);
    logic signed [XLEN-1:0] r;
    r = {{(XLEN-11){raw[10]}}, raw};
    return r;
  endfunction

  // Stage p0: combinational decode of the fetched instruction
  ctl_t                   ctl_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic                   adv;
  logic                   hazard;
  logic                   busy;
  logic                   accept;

  ctl_t                   ctl_p1;
  logic                   vld_p1;
  logic [5:0]             opc_p1;
  logic [4:0]             ra_p1;
  logic [4:0]             rb_p1;
  logic [4:0]             rd_p1;
  logic signed [XLEN-1:0] imm_p1;

  assign ctl_p0 = decode_ctl(F_inst[31:26], F_inst[15:11]);
  assign imm_p0 = sext_imm(F_inst[10:0]);

  assign adv    = !vld_p1 | E_ready;
  assign hazard = vld_p1 & ctl_p1.ld & ((rd_p1 == F_inst[25:21]) | (rd_p1 == F_inst[20:16]));
  assign F_ready = adv & !hazard & !busy & !flush;
  assign accept  = F_valid & F_ready;
  assign D_stall = F_valid & (hazard | busy);

`ifdef DECODE_MUL_INTERLOCK_EN
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  logic [CNT_W-1:0] mul_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              mul_cnt <= '0;
    else if (flush)                       mul_cnt <= '0;
    else if (vld_p1 & E_ready & ctl_p1.mul) mul_cnt <= CNT_W'(MUL_LAT - 1);
    else if (mul_cnt != '0)               mul_cnt <= mul_cnt - CNT_W'(1);
  end

  assign busy = (mul_cnt != '0);
`else
  assign busy = 1'b0;
`endif

  // Stage p1: ID/EX register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (flush)  vld_p1 <= 1'b0;
    else if (accept) vld_p1 <= 1'b1;
    else if (adv)    vld_p1 <= 1'b0;
  end

  // Data fields only move on accept so a bubble leaves the last bundle visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_p1 <= '0;
      ra_p1  <= '0;
      rb_p1  <= '0;
      rd_p1  <= '0;
      imm_p1 <= '0;
      ctl_p1 <= '0;
    end else if (accept) begin
      opc_p1 <= F_inst[31:26];
      ra_p1  <= F_inst[25:21];
      rb_p1  <= F_inst[20:16];
      rd_p1  <= F_inst[15:11];
      imm_p1 <= imm_p0;
      ctl_p1 <= ctl_p0;
    end
  end

  assign E_valid  = vld_p1;
  assign E_opc    = opc_p1;
  assign E_ra     = ra_p1;
  assign E_rb     = rb_p1;
  assign E_rd     = rd_p1;
  assign E_imm    = imm_p1;
  assign E_we     = ctl_p1.we;
  assign E_alu_op = ctl_p1.alu_op;
  assign E_ld     = ctl_p1.ld;
  assign E_str    = ctl_p1.str;
  assign E_byt    = ctl_p1.byt;
  assign E_brn    = ctl_p1.brn;
  assign E_addi   = ctl_p1.addi;
  assign E_mul    = ctl_p1.mul;

endmodule

// File: tb/tb_decode_pipe.sv
`timescale 1ns/1ps
// tb_decode_pipe: directed plus randomized stimulus for decode_pipe, checked by a scoreboard
// fed from a reference model of the decode table and issue rules.
module tb_decode_pipe;
  localparam int XLEN    = 32;
  localparam int MUL_LAT = 3;
`ifdef DECODE_MUL_INTERLOCK_EN
  localparam int MUL_STALL = MUL_LAT - 1;
`else
  localparam int MUL_STALL = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            F_valid;
  logic [XLEN-1:0] F_inst;
  logic            F_ready;
  logic            flush;
  logic            E_ready;
  logic            E_valid;
  logic [5:0]      E_opc;
  logic [4:0]      E_ra, E_rb, E_rd;
  logic [XLEN-1:0] E_imm;
  logic            E_we;
  logic [3:0]      E_alu_op;
  logic            E_ld, E_str, E_byt, E_brn, E_addi, E_mul;
  logic            D_stall;

  decode_pipe #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .F_valid(F_valid), .F_inst(F_inst), .F_ready(F_ready),
    .flush(flush), .E_ready(E_ready), .E_valid(E_valid), .E_opc(E_opc), .E_ra(E_ra),
    .E_rb(E_rb), .E_rd(E_rd), .E_imm(E_imm), .E_we(E_we), .E_alu_op(E_alu_op),
    .E_ld(E_ld), .E_str(E_str), .E_byt(E_byt), .E_brn(E_brn), .E_addi(E_addi),
    .E_mul(E_mul), .D_stall(D_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  opc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        we;
    logic [3:0]  alu_op;
    logic        ld;
    logic        str;
    logic        byt;
    logic        brn;
    logic        addi;
    logic        mul;
  } exp_t;

  logic [63:0] act_bundle;
  assign act_bundle = {E_opc, E_ra, E_rb, E_rd, E_imm, E_we, E_alu_op,
                       E_ld, E_str, E_byt, E_brn, E_addi, E_mul};

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  // Reference decode written from the instruction-set table.
  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t e;
    int   op;
    int   sub;
    int   raw;
    op  = int'(i[31:26]);
    sub = int'(i[15:11]);
    raw = int'(i[10:0]);
    e.opc  = i[31:26];
    e.ra   = i[25:21];
    e.rb   = i[20:16];
    e.rd   = i[15:11];
    e.imm  = (raw >= 1024) ? 32'(raw - 2048) : 32'(raw);
    e.mul  = (op == 14);
    e.brn  = (op == 13);
    e.addi = (op == 8);
    e.ld   = ((op % 32) == 11);
    e.str  = ((op % 32) == 12);
    e.byt  = (op >= 32);
    if (op < 8 || op == 9 || op == 10)          e.alu_op = 4'(op);
    else if (op == 14)                          e.alu_op = 4'd11;
    else if (op == 13 && sub >= 1 && sub <= 3)  e.alu_op = 4'(7 + sub);
    else                                        e.alu_op = 4'd0;
    e.we = (op <= 10) || e.ld || e.mul;
    return e;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [5:0] opc;
    case ($urandom_range(0, 5))
      0:       opc = 6'd11;
      1:       opc = 6'd14;
      2:       opc = 6'd13;
      default: opc = 6'($urandom_range(0, 63));
    endcase
    return {opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)};
  endfunction

  // Reference model: what sits in EX, and how many issue cycles the MUL still blocks.
  bit   m_vld = 1'b0;
  exp_t m_ent;
  int   m_cnt = 0;

  always begin : model
    logic hz, adv, rdy;
    @(negedge clk);
    #2;
    if (rst) begin
      m_vld = 1'b0;
      m_cnt = 0;
      exp_q.delete();
    end else begin
      hz  = m_vld && m_ent.ld && (m_ent.rd == F_inst[25:21] || m_ent.rd == F_inst[20:16]);
      adv = !m_vld || E_ready;
      rdy = adv && !hz && (m_cnt == 0) && !flush;
      check("f_ready", 64'(F_ready), 64'(rdy));
      check("d_stall", 64'(D_stall), 64'(F_valid && (hz || m_cnt != 0)));
      if (flush) begin
        if (m_vld && !E_ready) void'(exp_q.pop_back());
        m_vld = 1'b0;
        m_cnt = 0;
      end else begin
        if (m_vld && E_ready && m_ent.mul) m_cnt = MUL_STALL;
        else if (m_cnt > 0)                m_cnt--;
        if (F_valid && rdy) begin
          m_ent = ref_decode(F_inst);
          m_vld = 1'b1;
          exp_q.push_back(m_ent);
        end else if (adv) begin
          m_vld = 1'b0;
        end
      end
    end
  end

  // Monitor: the head of the queue must be on E whenever E is valid.
  always begin : monitor
    @(negedge clk);
    if (!rst) begin
      check("e_valid", 64'(E_valid), 64'(exp_q.size() != 0));
      if (E_valid && exp_q.size() != 0) begin
        check("e_bundle", act_bundle, 64'(exp_q[0]));
        if (E_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] inst, output int stalls);
    int n;
    n = 0;
    F_valid = 1'b1;
    F_inst  = inst;
    forever begin
      @(negedge clk);
      if (F_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        $display("FAIL send_timeout: waited %0d cycles for F_ready, required accept", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    F_valid = 1'b0;
    stalls  = n;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int s;
    rst = 1'b1; F_valid = 1'b0; F_inst = '0; flush = 1'b0; E_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_f_ready", 64'(F_ready), 64'(1));
    check("reset_e_valid", 64'(E_valid), 64'(0));
    @(posedge clk); #1;

    send(32'h00221800, s);
    check("add_valid", 64'(E_valid), 64'(1));
    check("add_ra", 64'(E_ra), 64'(1));
    check("add_rb", 64'(E_rb), 64'(2));
    check("add_rd", 64'(E_rd), 64'(3));
    check("add_we", 64'(E_we), 64'(1));
    check("add_alu", 64'(E_alu_op), 64'(0));
    send(32'h202007FF, s);
    check("addi_imm", 64'(E_imm), 64'(32'hFFFFFFFF));
    check("addi_flag", 64'(E_addi), 64'(1));
    send(32'h34001000, s);
    check("blt_brn", 64'(E_brn), 64'(1));
    check("blt_alu", 64'(E_alu_op), 64'(9));
    check("blt_we", 64'(E_we), 64'(0));

    send(32'h2C002000, s);
    send(32'h00800000, s);
    check("load_use_stalls", 64'(s), 64'(1));

    repeat (2) @(posedge clk);
    #1;
    send(32'h38000000, s);
    send(32'h00000000, s);
    send(32'h00000000, s);
    check("mul_stalls", 64'(s), 64'(MUL_STALL));

    repeat (4) @(posedge clk);
    #1 E_ready = 1'b0;
    send(32'h04A52AAA, s);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", act_bundle, 64'(ref_decode(32'h04A52AAA)));
    end
    @(posedge clk); #1;
    flush = 1'b1; F_valid = 1'b1; F_inst = 32'h0C631800;
    @(negedge clk);
    check("flush_f_ready", 64'(F_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0; F_valid = 1'b0;
    @(negedge clk);
    check("flush_e_valid", 64'(E_valid), 64'(0));

    @(posedge clk); #1;
    send(32'h14421000, s);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_e_valid", 64'(E_valid), 64'(0));
    check("rst_mid_fields", act_bundle, 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; E_ready = 1'b1;
    @(negedge clk);
    check("rst_release_f_ready", 64'(F_ready), 64'(1));

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      E_ready = ($urandom_range(0, 9) < 7);
      flush   = !E_ready && ($urandom_range(0, 11) == 0);
      F_valid = ($urandom_range(0, 3) != 0);
      F_inst  = rnd_inst();
    end

    @(posedge clk); #1;
    F_valid = 1'b0; flush = 1'b0; E_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #3;
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Registered decode stage with a valid/ready handshake on both sides. It takes fetched instructions, produces the same field and control decode the core uses, and holds them in an ID/EX pipeline register. It adds load-use hazard bubbles, a multi-cycle MUL issue interlock, backpressure, and a synchronous flush from EX on taken branches. It sits between fetch and execute, generalised over data width and multiplier latency.

## Interface
- XLEN, 32: instruction and immediate width; must be ≥ 32.
- MUL_LAT, 3: EX cycles occupied by a MUL; must be ≥ 1.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- F_valid  in  1  fetch presents an instruction.
- F_inst  in  XLEN  instruction; fields are taken from bits [31:0].
- F_ready  out  1  decode accepts F_inst this cycle.
- flush  in  1  EX redirect; kill the held and the incoming instruction.
- E_ready  in  1  EX accepts the E_* bundle.
- E_valid  out  1  E_* bundle is valid.
- E_opc  out  6  opcode, F_inst[31:26].
- E_ra  out  5  source register A, F_inst[25:21].
- E_rb  out  5  source register B, F_inst[20:16].
- E_rd  out  5  destination or branch sub-op, F_inst[15:11].
- E_imm  out  XLEN  sign-extended F_inst[10:0].
- E_we  out  1  register write enable.
- E_alu_op  out  4  ALU operation.
- E_ld  out  1  load.
- E_str  out  1  store.
- E_byt  out  1  byte access.
- E_brn  out  1  control transfer.
- E_addi  out  1  add immediate.
- E_mul  out  1  multiply.
- D_stall  out  1  hazard or interlock is blocking issue (debug/perf).

## Operation
Decode rules:
- Opcodes 0–7 (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR): alu_op = opc[3:0].
- ADDI = 8: alu_op 0, addi = 1.
- LT = 9: alu_op 9.
- GT = 10: alu_op 10.
- MUL = 14: alu_op 11, mul = 1.
- ld when opc[4:0] = 01011; str when opc[4:0] = 01100; byt = opc[5].
- CTRL = 13: brn = 1; rd selects JMP = 0 (alu_op 0), BEQ = 1 (alu_op 8), BLT = 2 (alu_op 9), BGT = 3 (alu_op 10).
- we = (opc ≤ 10, unsigned) | ld | mul.
- Any other encoding: alu_op 0, all flags 0 except those the rules above set.

Pipeline and hazards:
- adv = !E_valid | E_ready.
- Load-use hazard: E_valid & E_ld & (E_rd == F_inst.ra | E_rd == F_inst.rb). Compare both sources unconditionally; r0 is not special-cased.
- mul_cnt: loaded with MUL_LAT−1 on an E_valid & E_ready & E_mul handshake; otherwise decrements to 0. busy = (mul_cnt ≠ 0).
- F_ready = adv & !hazard & !busy & !flush.
- D_stall = F_valid & (hazard | busy).
- Register update priority, highest first:
  - rst
  - flush → E_valid ← 0, mul_cnt ← 0
  - adv & F_valid & F_ready → load the decode, E_valid ← 1
  - adv → E_valid ← 0 (bubble)
  - else hold
- While E_valid & !E_ready, every E_* output holds stable.
- The data fields (E_opc … E_mul) load only on accept; they keep their old values while a bubble is issued.

## Timing
- Latency: one cycle from an F handshake to E_valid.
- Throughput: one instruction per cycle with no hazards.
- F_ready depends combinationally on E_ready, flush, E_* and mul_cnt. All E_* outputs are registers.
- Reset, async assert: E_valid 0, every E_* field 0, mul_cnt 0. F_ready reads 1 while rst is low and no flush.
- Reset asserted mid-operation drops the in-flight instruction with no handshake.
- Load-use inserts exactly one bubble, since the load leaves E on the next E_ready.
- MUL interlock holds F_ready low for MUL_LAT−1 cycles after the MUL handshake. MUL_LAT = 1 gives no stall.
- flush and an F handshake in the same cycle: the instruction is not accepted, because F_ready is 0.
- flush while a MUL interlock is active cancels the interlock.

## Configuration
- DECODE_MUL_INTERLOCK_EN defined: mul_cnt is present and behaves as above.
- Not defined: mul_cnt is removed and busy is tied 0, so a MUL issues back-to-back with no stall. MUL decode is unchanged.

## Test plan
- Reset: assert rst mid-stream with E_valid = 1 → E_valid and all E_* are 0 immediately; F_ready = 1 on the first cycle after release.
- ALU and immediate decode:
  - F_inst 0x00221800 → next cycle E_valid 1, ra 1, rb 2, rd 3, we 1, alu_op 0.
  - 0x202007FF → E_imm 0xFFFFFFFF, addi 1.
- Load-use: 0x2C002000 (LOAD rd 4) then 0x00800000 (ADD ra 4) with E_ready = 1 → one cycle of F_ready 0, D_stall 1, E_valid 0, then the ADD issues.
- Branch: 0x34001000 → E_brn 1, alu_op 9, we 0.
- MUL interlock, MUL_LAT = 3, macro defined: MUL then ADD → F_ready 0 for 2 cycles after the MUL handshake. With the macro undefined → 0 stall cycles.
- Backpressure and flush:
  - E_ready 0 for 3 cycles → E_* stable.
  - Then flush 1 with F_valid 1 → E_valid 0 next cycle, F_ready 0, and that instruction never appears on E.
